fetch_prefetch_queue: RTL and testbench

//  Instruction prefetch unit feeding the IF/ID latch of the 5-stage MIPS pipeline.

---
 rtl/fetch_prefetch_queue_if.sv | 21 ++
 rtl/fetch_prefetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response channel between the prefetch queue and imem.
// Requests use a valid/ready handshake; responses return in request order.
interface fetch_prefetch_queue_if;
   localparam int unsigned XLEN = 32;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue feeding IF/ID: in-order imem requests, DEPTH-entry
// buffer of {word, PC+4}, branch flush with drop counting of late responses.
module fetch_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          rst,
   fetch_prefetch_queue_if.master        imem,
   input  logic                          ex_mem_pc_src,
   input  logic [31:0]                   ex_mem_npc,
   input  logic                          stall,
   output logic [31:0]                   if_id_instr,
   output logic [31:0]                   if_id_npc,
   output logic                          if_id_valid
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [31:0]   r_pc;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_alloc_cnt;
   logic [CW-1:0] r_fill_cnt;
   logic [CW-1:0] r_drop_cnt;
   logic [31:0]   r_data [DEPTH];
   logic [31:0]   r_npc  [DEPTH];

   logic          w_req_valid;
   logic          w_acc;
   logic          w_drop;
   logic          w_fill;
   logic          w_pop;
   logic [CW-1:0] w_unfilled;
   logic [PW-1:0] w_fill_ptr;
   logic [31:0]   w_head_instr;

   logic [31:0]   w_pc_nxt;
   logic [PW-1:0] w_head_nxt;
   logic [PW-1:0] w_tail_nxt;
   logic [CW-1:0] w_alloc_nxt;
   logic [CW-1:0] w_fill_nxt;
   logic [CW-1:0] w_drop_nxt;

   // Entries fill strictly in order, so the oldest unfilled one sits fill_cnt past head.
   assign w_unfilled   = r_alloc_cnt - r_fill_cnt;
   assign w_fill_ptr   = r_head + PW'(r_fill_cnt);
   assign w_req_valid  = rst && !ex_mem_pc_src && ((r_alloc_cnt + r_drop_cnt) < CW'(DEPTH));
   assign w_acc        = w_req_valid && imem.imem_req_ready;
   assign w_drop       = imem.imem_rsp_valid && (r_drop_cnt != '0);
   assign w_fill       = imem.imem_rsp_valid && (r_drop_cnt == '0) && (w_unfilled != '0);
   assign w_pop        = !ex_mem_pc_src && !stall && ((r_fill_cnt != '0) || w_fill);
   assign w_head_instr = (r_fill_cnt != '0) ? r_data[r_head] : imem.imem_rsp_data;

   assign imem.imem_req_valid = w_req_valid;
   assign imem.imem_req_addr  = r_pc;

   always_comb begin
      w_pc_nxt    = r_pc;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      w_alloc_nxt = r_alloc_cnt;
      w_fill_nxt  = r_fill_cnt;
      w_drop_nxt  = r_drop_cnt;
      if (ex_mem_pc_src) begin
         // Every still-unfilled entry will see its word arrive later and must be discarded.
         w_pc_nxt    = ex_mem_npc;
         w_head_nxt  = '0;
         w_tail_nxt  = '0;
         w_alloc_nxt = '0;
         w_fill_nxt  = '0;
         w_drop_nxt  = r_drop_cnt + w_unfilled - CW'(w_drop) - CW'(w_fill);
      end else begin
         w_head_nxt  = r_head + PW'(w_pop);
         w_tail_nxt  = r_tail + PW'(w_acc);
         w_alloc_nxt = r_alloc_cnt + CW'(w_acc) - CW'(w_pop);
         w_fill_nxt  = r_fill_cnt + CW'(w_fill) - CW'(w_pop);
         w_drop_nxt  = r_drop_cnt - CW'(w_drop);
         if (w_acc) w_pc_nxt = r_pc + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc        <= RESET_PC;
         r_head      <= '0;
         r_tail      <= '0;
         r_alloc_cnt <= '0;
         r_fill_cnt  <= '0;
         r_drop_cnt  <= '0;
         if_id_instr <= '0;
         if_id_npc   <= '0;
         if_id_valid <= 1'b0;
      end else begin
         r_pc        <= w_pc_nxt;
         r_head      <= w_head_nxt;
         r_tail      <= w_tail_nxt;
         r_alloc_cnt <= w_alloc_nxt;
         r_fill_cnt  <= w_fill_nxt;
         r_drop_cnt  <= w_drop_nxt;
         if (ex_mem_pc_src) begin
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
         end else if (!stall) begin
            if (w_pop) begin
               if_id_instr <= w_head_instr;
               if_id_npc   <= r_npc[r_head];
               if_id_valid <= 1'b1;
            end else begin
               if_id_instr <= '0;
               if_id_valid <= 1'b0;
            end
         end
      end
   end

   // Payload storage carries no reset; occupancy is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (w_fill) r_data[w_fill_ptr] <= imem.imem_rsp_data;
      if (w_acc)  r_npc[r_tail]      <= r_pc + 32'd4;
   end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order variable-latency imem model plus a
// queue-level reference of the prefetch buffer, checked every cycle.
module tb_fetch_prefetch_queue;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_src;
   logic [31:0] br_npc;
   logic        stall;
   logic [31:0] instr;
   logic [31:0] npc;
   logic        valid;

   always #5 clk = ~clk;

   fetch_prefetch_queue_if bus ();

   fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (bus),
      .ex_mem_pc_src (pc_src),
      .ex_mem_npc    (br_npc),
      .stall         (stall),
      .if_id_instr   (instr),
      .if_id_npc     (npc),
      .if_id_valid   (valid)
   );

   typedef struct { logic [31:0] data; logic [31:0] npc; bit filled; } ent_t;
   typedef struct { logic [31:0] data; int due; } mrsp_t;

   ent_t        mq[$];
   mrsp_t       memq[$];
   int          m_drop;
   logic [31:0] m_pc, m_instr, m_npc;
   bit          m_valid;
   int          cyc, wait_min, wait_max;
   bit          rdy_rand, rsp_rand;
   int          n_checks = 0;
   int          n_pass = 0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic int unf_cnt();
      int n = 0;
      foreach (mq[i]) if (!mq[i].filled) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      memq.delete();
      m_drop  = 0;
      m_pc    = 32'h0;
      m_instr = 32'h0;
      m_npc   = 32'h0;
      m_valid = 1'b0;
   endtask

   // One clock: drive memory response, check request side, advance model, check IF/ID.
   task automatic step();
      bit          exp_rv, acc, rsp, fill_now, dropped;
      int          unf;
      logic [31:0] rdata;
      ent_t        e;
      if (rdy_rand) bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      rsp = (memq.size() > 0) && (memq[0].due <= cyc) && (!rsp_rand || ($urandom_range(1, 0) == 1));
      rdata = rsp ? memq[0].data : $urandom();
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rdata;
      #1;
      exp_rv = !pc_src && (mq.size() + m_drop < DEPTH);
      chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
      acc = exp_rv && bus.imem_req_ready;
      @(posedge clk);
      if (rsp) void'(memq.pop_front());
      if (acc) memq.push_back('{word_of(m_pc), cyc + 1 + int'($urandom_range(wait_max, wait_min))});
      cyc++;
      unf      = unf_cnt();
      fill_now = rsp && (m_drop == 0) && (unf > 0);
      dropped  = rsp && (m_drop > 0);
      if (fill_now) begin
         for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
               mq[i].data   = rdata;
               mq[i].filled = 1'b1;
               break;
            end
         end
      end
      if (pc_src) begin
         m_drop  = m_drop - int'(dropped) + unf - int'(fill_now);
         mq.delete();
         m_pc    = br_npc;
         m_instr = 32'h0;
         m_valid = 1'b0;
      end else begin
         m_drop = m_drop - int'(dropped);
         if (!stall) begin
            if (mq.size() > 0 && mq[0].filled) begin
               e       = mq.pop_front();
               m_instr = e.data;
               m_npc   = e.npc;
               m_valid = 1'b1;
            end else begin
               m_instr = 32'h0;
               m_valid = 1'b0;
            end
         end
         if (acc) begin
            mq.push_back('{32'h0, m_pc + 32'd4, 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
      chk("if_id_valid", 32'(valid), 32'(m_valid));
      chk("if_id_instr", instr, m_instr);
      chk("if_id_npc", npc, m_npc);
      if (m_valid) chk("instr_matches_npc", instr, word_of(m_npc - 32'd4));
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag, input logic [31:0] want_npc);
      int n = 0;
      while (valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 32'(valid), 32'h1);
      chk({tag, "_npc"}, npc, want_npc);
      chk({tag, "_instr"}, instr, word_of(want_npc - 32'd4));
   endtask

   initial begin
      int max_out, nv, n;
      rst = 1'b0; pc_src = 1'b0; br_npc = 32'h0; stall = 1'b0;
      bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
      wait_min = 0; wait_max = 0; rdy_rand = 1'b0; rsp_rand = 1'b0; cyc = 0;
      model_reset();
      #12;
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_npc", npc, 32'h0);
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Zero-wait memory: first word on the 2nd edge after accept, then 1/cycle.
      step();
      chk("t1_edge1_valid", 32'(valid), 32'h0);
      step();
      chk("t1_edge2_valid", 32'(valid), 32'h1);
      chk("t1_edge2_npc", npc, 32'h4);
      step();
      chk("t1_edge3_npc", npc, 32'h8);
      repeat (12) step();

      // Three wait states: in-flight limit reaches DEPTH.
      wait_min = 3; wait_max = 3; max_out = 0;
      repeat (30) begin
         step();
         if (memq.size() > max_out) max_out = memq.size();
      end
      chk("t2_outstanding", 32'(max_out), 32'(DEPTH));

      // Stall 5 cycles while filling, then back-to-back drain.
      wait_min = 0; wait_max = 0;
      repeat (6) step();
      stall = 1'b1;
      repeat (5) step();
      stall = 1'b0;
      nv = 0;
      repeat (8) begin
         step();
         if (valid === 1'b1) nv++;
      end
      chk("t3_backtoback", 32'(nv), 32'h8);

      // Branch to 0x100 with two responses still in flight.
      wait_min = 3; wait_max = 3;
      bus.imem_req_ready = 1'b0;
      repeat (8) step();
      bus.imem_req_ready = 1'b1;
      repeat (2) step();
      bus.imem_req_ready = 1'b0;
      pc_src = 1'b1; br_npc = 32'h100;
      step();
      pc_src = 1'b0;
      bus.imem_req_ready = 1'b1;
      chk("t4_bubble", 32'(valid), 32'h0);
      wait_valid("t4_first", 32'h104);
      repeat (6) step();

      // Flush with stall on a response cycle.
      n = 0;
      while (!((memq.size() > 0) && (memq[0].due <= cyc) && (m_drop == 0)) && n < 40) begin
         step();
         n++;
      end
      chk("t5_found_rsp_cycle", 32'(n < 40), 32'h1);
      pc_src = 1'b1; stall = 1'b1; br_npc = 32'h100;
      step();
      pc_src = 1'b0; stall = 1'b0;
      #1;
      chk("t5_next_req_addr", bus.imem_req_addr, 32'h100);
      wait_valid("t5_first", 32'h104);

      // Randomized traffic with latency, backpressure, stalls and flushes (incl. PC wrap).
      wait_min = 0; wait_max = 4; rdy_rand = 1'b1; rsp_rand = 1'b1;
      pc_src = 1'b1; br_npc = 32'hFFFF_FFF8;
      step();
      pc_src = 1'b0;
      repeat (400) begin
         stall  = ($urandom_range(3, 0) == 0);
         pc_src = ($urandom_range(15, 0) == 0);
         br_npc = $urandom() & 32'hFFFF_FFFC;
         step();
      end
      pc_src = 1'b0; stall = 1'b0; rdy_rand = 1'b0; rsp_rand = 1'b0;
      bus.imem_req_ready = 1'b1;

      // Async reset with a full queue.
      wait_min = 0; wait_max = 0;
      stall = 1'b1;
      repeat (8) step();
      #2;
      rst = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      #1;
      chk("t6_async_valid", 32'(valid), 32'h0);
      chk("t6_async_instr", instr, 32'h0);
      chk("t6_async_npc", npc, 32'h0);
      chk("t6_async_req_valid", 32'(bus.imem_req_valid), 32'h0);
      model_reset();
      stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_restart_addr", bus.imem_req_addr, 32'h0);
      step();
      step();
      chk("t6_first_npc", npc, 32'h4);
      repeat (10) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
